// File: rtl/self_attention_pkg.sv
// Shared definitions for the self-attention head and its operand feeders.
package self_attention_pkg;

  localparam int DEF_K_BLOCKS    = 4;
  localparam int DEF_NUM_ROW_BLK = 2;
  localparam int DEF_NUM_COL_BLK = 2;

  localparam int W_SLICE_WIDTH_DEF    = 16;
  localparam int W0_SLICE_WIDTH_DEF   = 16;
  localparam int TOTAL_INPUT_W_DEF    = 2;
  localparam int TOTAL_INPUT_W_W0_DEF = 2;
  localparam int N_MODULE_WIDTH_DEF   = 32;
  localparam int N0_MODULE_WIDTH_DEF  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SYS_RST,
    S_RUN,
    S_ACC_WAIT,
    S_DONE
  } feeder_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/qn_knt_feeder_tile_counter.sv
// Nested k/c/r slice counters; buffer addresses are kept as registers and
// stepped incrementally so they come straight from flops.
module feeder_tile_counter
  import self_attention_pkg::*;
#(
  parameter int K_BLOCKS    = DEF_K_BLOCKS,
  parameter int NUM_ROW_BLK = DEF_NUM_ROW_BLK,
  parameter int NUM_COL_BLK = DEF_NUM_COL_BLK,
  parameter int N_ADDR_W    = addr_w(NUM_ROW_BLK * K_BLOCKS),
  parameter int W_ADDR_W    = addr_w(NUM_COL_BLK * K_BLOCKS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc_k,
  input  logic                inc_tile,
  output logic                first_k,
  output logic                last_k,
  output logic                last_tile,
  output logic [N_ADDR_W-1:0] n_addr,
  output logic [W_ADDR_W-1:0] w_addr
);

  localparam int K_W = addr_w(K_BLOCKS);
  localparam int C_W = addr_w(NUM_COL_BLK);
  localparam int R_W = addr_w(NUM_ROW_BLK);

  logic [K_W-1:0]      k;
  logic [C_W-1:0]      c;
  logic [R_W-1:0]      r;
  logic [N_ADDR_W-1:0] n_base;
  logic                last_c;
  logic                last_r;

  assign first_k   = (k == '0);
  assign last_k    = (k == K_W'(K_BLOCKS - 1));
  assign last_c    = (c == C_W'(NUM_COL_BLK - 1));
  assign last_r    = (r == R_W'(NUM_ROW_BLK - 1));
  assign last_tile = last_c && last_r;

  // n_base tracks r*K_BLOCKS so no multiplier is needed on the address path.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      k      <= '0;
      c      <= '0;
      r      <= '0;
      n_base <= '0;
      n_addr <= '0;
      w_addr <= '0;
    end else if (inc_k) begin
      k      <= k + 1'b1;
      n_addr <= n_addr + 1'b1;
      w_addr <= w_addr + 1'b1;
    end else if (inc_tile) begin
      k <= '0;
      if (last_c) begin
        c      <= '0;
        w_addr <= '0;
        if (last_r) begin
          r      <= '0;
          n_base <= '0;
          n_addr <= '0;
        end else begin
          r      <= r + 1'b1;
          n_base <= n_base + N_ADDR_W'(K_BLOCKS);
          n_addr <= n_base + N_ADDR_W'(K_BLOCKS);
        end
      end else begin
        c      <= c + 1'b1;
        w_addr <= w_addr + 1'b1;
        n_addr <= n_base;
      end
    end
  end

endmodule

// File: rtl/qn_knt_feeder.sv
// Feeds Qn/KnT operand slices into the head's Qn x KnT systolic stage.
// state     | meaning
// IDLE      | waiting for start
// FETCH     | buffer read strobes for the current slice
// LOAD      | read data captured into the operand registers
// SYS_RST   | systolic array reset, accumulator clear on k==0
// RUN       | array enabled until the slice finishes
// ACC_WAIT  | last slice done, waiting for tile accumulation
// DONE      | one-cycle completion pulse
module qn_knt_feeder
  import self_attention_pkg::*;
#(
  parameter int W_SLICE_WIDTH    = W_SLICE_WIDTH_DEF,
  parameter int W0_SLICE_WIDTH   = W0_SLICE_WIDTH_DEF,
  parameter int TOTAL_INPUT_W    = TOTAL_INPUT_W_DEF,
  parameter int TOTAL_INPUT_W_W0 = TOTAL_INPUT_W_W0_DEF,
  parameter int N_MODULE_WIDTH   = N_MODULE_WIDTH_DEF,
  parameter int N0_MODULE_WIDTH  = N0_MODULE_WIDTH_DEF,
  parameter int K_BLOCKS         = DEF_K_BLOCKS,
  parameter int NUM_ROW_BLK      = DEF_NUM_ROW_BLK,
  parameter int NUM_COL_BLK      = DEF_NUM_COL_BLK,
  parameter int N_ADDR_W         = addr_w(NUM_ROW_BLK * K_BLOCKS),
  parameter int W_ADDR_W         = addr_w(NUM_COL_BLK * K_BLOCKS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  n_rd_en,
  output logic [N_ADDR_W-1:0]                   n_rd_addr,
  input  logic [N_MODULE_WIDTH-1:0]             n_rd_data,
  output logic                                  w_rd_en,
  output logic [W_ADDR_W-1:0]                   w_rd_addr,
  input  logic [TOTAL_INPUT_W*W_SLICE_WIDTH-1:0] w_rd_data,
  output logic                                  en_Qn_KnT,
  output logic                                  rst_n_Qn_KnT,
  output logic                                  reset_acc_Qn_KnT,
  output logic                                  out_valid_Qn_KnT,
  output logic [W_SLICE_WIDTH-1:0]              input_w_Qn_KnT [TOTAL_INPUT_W],
  output logic [N_MODULE_WIDTH-1:0]             input_n_Qn_KnT,
  input  logic                                  sys_finish_wrap_Qn_KnT,
  input  logic                                  acc_done_wrap_Qn_KnT
);

  if (K_BLOCKS < 1 || NUM_ROW_BLK < 1 || NUM_COL_BLK < 1 ||
      W_SLICE_WIDTH < 1 || W0_SLICE_WIDTH < 1 ||
      TOTAL_INPUT_W < 1 || TOTAL_INPUT_W_W0 < 1 ||
      N_MODULE_WIDTH < 1 || N0_MODULE_WIDTH < 1 ||
      (1 << N_ADDR_W) < NUM_ROW_BLK * K_BLOCKS ||
      (1 << W_ADDR_W) < NUM_COL_BLK * K_BLOCKS) begin : g_bad_params
    $error("qn_knt_feeder: inconsistent parameter set");
  end

  feeder_state_t state;
  feeder_state_t next_state;
  logic          inc_k;
  logic          inc_tile;
  logic          first_k;
  logic          last_k;
  logic          last_tile;
  logic          cnt_clear;

  assign cnt_clear = (state == S_IDLE) || abort;

  feeder_tile_counter #(
    .K_BLOCKS    (K_BLOCKS),
    .NUM_ROW_BLK (NUM_ROW_BLK),
    .NUM_COL_BLK (NUM_COL_BLK),
    .N_ADDR_W    (N_ADDR_W),
    .W_ADDR_W    (W_ADDR_W)
  ) u_tile_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .inc_k     (inc_k),
    .inc_tile  (inc_tile),
    .first_k   (first_k),
    .last_k    (last_k),
    .last_tile (last_tile),
    .n_addr    (n_rd_addr),
    .w_addr    (w_rd_addr)
  );

  always_comb begin
    next_state = state;
    inc_k      = 1'b0;
    inc_tile   = 1'b0;
    case (state)
      S_IDLE:    if (start) next_state = S_FETCH;
      S_FETCH:   next_state = S_LOAD;
      S_LOAD:    next_state = S_SYS_RST;
      S_SYS_RST: next_state = S_RUN;
      S_RUN: begin
        if (sys_finish_wrap_Qn_KnT) begin
          if (!last_k) begin
            inc_k      = 1'b1;
            next_state = S_FETCH;
          end else if (acc_done_wrap_Qn_KnT) begin
            // accumulation already finished: skip ACC_WAIT entirely
            inc_tile   = 1'b1;
            next_state = last_tile ? S_DONE : S_FETCH;
          end else begin
            next_state = S_ACC_WAIT;
          end
        end
      end
      S_ACC_WAIT: begin
        if (acc_done_wrap_Qn_KnT) begin
          inc_tile   = 1'b1;
          next_state = last_tile ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (abort) begin
      next_state = S_IDLE;
      inc_k      = 1'b0;
      inc_tile   = 1'b0;
    end
  end

  // Control outputs are decoded from next_state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      n_rd_en          <= 1'b0;
      w_rd_en          <= 1'b0;
      en_Qn_KnT        <= 1'b0;
      rst_n_Qn_KnT     <= 1'b0;
      reset_acc_Qn_KnT <= 1'b0;
      out_valid_Qn_KnT <= 1'b0;
    end else begin
      state            <= next_state;
      busy             <= (next_state != S_IDLE) && (next_state != S_DONE);
      done             <= (next_state == S_DONE);
      n_rd_en          <= (next_state == S_FETCH);
      w_rd_en          <= (next_state == S_FETCH);
      en_Qn_KnT        <= (next_state == S_RUN);
      rst_n_Qn_KnT     <= !((next_state == S_SYS_RST) || abort);
      reset_acc_Qn_KnT <= (next_state == S_SYS_RST) && first_k;
      out_valid_Qn_KnT <= (next_state == S_RUN) && last_k;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      input_n_Qn_KnT <= '0;
      for (int j = 0; j < TOTAL_INPUT_W; j++) begin
        input_w_Qn_KnT[j] <= '0;
      end
    end else if (state == S_LOAD && !abort) begin
      input_n_Qn_KnT <= n_rd_data;
      for (int j = 0; j < TOTAL_INPUT_W; j++) begin
        input_w_Qn_KnT[j] <= w_rd_data[j*W_SLICE_WIDTH +: W_SLICE_WIDTH];
      end
    end
  end

endmodule
